// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared encodings for the flash arbiter slice.
// Holds the command op codes, the sequencer state type and the default
// start-wait window used when the driver does not acknowledge a strobe.
package flash_arb_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam int START_WAIT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RESP
  } arb_state_t;

endpackage

// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if: requester-side bundle of the flash arbiter.
// Carries both command ports plus the shared response (ack/err/rdata/grant).
// The arbiter uses the slave view; the requesters use the master view.
interface flash_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
);

  logic              req0;
  logic              req1;
  logic [1:0]        op0;
  logic [1:0]        op1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              grant;

  modport slave (
    input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, err, rdata, grant
  );

  modport master (
    output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, err, rdata, grant
  );

endinterface

// File: rtl/flash_arb_rr.sv
// flash_arb_rr: two-input round-robin picker.
// A lone requester always wins; on a tie the port that was not served
// last wins, so two continuously requesting ports alternate.
module flash_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

  // Pick the winning port from the request pair and the previous owner
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one flash_driver between the boot loader (port 0)
// and the CPU memory path (port 1). Commands arrive on a req/ack handshake,
// are arbitrated round-robin, strobed into the driver and tracked through
// the driver's busy phase before acking.
// Optional busy-phase watchdog: define FLASH_ARB_TIMEOUT_EN.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 16,
  parameter int START_WAIT = START_WAIT_DEF
`ifdef FLASH_ARB_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  flash_arbiter_if.slave    bus,
  output logic [ADDR_W-1:0] drv_addr,
  output logic [DATA_W-1:0] drv_wdata,
  input  logic [DATA_W-1:0] drv_rdata,
  output logic              drv_en_read,
  output logic              drv_en_write,
  output logic              drv_en_erase,
  input  logic              drv_busy
);

  arb_state_t        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              win, win_valid;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
`ifdef FLASH_ARB_TIMEOUT_EN
  logic [23:0]       tcnt_q, tcnt_d;
`endif

  flash_arb_rr u_rr (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_q),
    .winner     (win),
    .valid      (win_valid)
  );

  // Route the winning port's command fields toward the latch registers
  always_comb begin
    sel_op    = win ? bus.op1    : bus.op0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  // Next-state and register-update logic of the command sequencer
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    err_d   = err_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wcnt_d  = '0;
`ifdef FLASH_ARB_TIMEOUT_EN
    tcnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (!drv_busy && win_valid) begin
          grant_d = win;
          op_d    = sel_op;
          err_d   = (sel_op == OP_RSVD);
          if (sel_op == OP_RSVD) begin
            state_d = RESP;
          end else begin
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (drv_busy) begin
          state_d = WAIT_DONE;
        end else if (wcnt_q == 8'(START_WAIT - 1)) begin
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!drv_busy) begin
          if (op_q == OP_READ) begin
            rdata_d = drv_rdata;
          end
          state_d = RESP;
        end
`ifdef FLASH_ARB_TIMEOUT_EN
        else if (tcnt_q == TIMEOUT_CYCLES - 24'd1) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 24'd1;
        end
`endif
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state register; reset drops any strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command, response and counter registers; port 0 is favoured after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      err_q   <= err_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
`ifdef FLASH_ARB_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  assign drv_addr     = addr_q;
  assign drv_wdata    = wdata_q;
  assign drv_en_read  = (state_q == ISSUE) && (op_q == OP_READ);
  assign drv_en_write = (state_q == ISSUE) && (op_q == OP_WRITE);
  assign drv_en_erase = (state_q == ISSUE) && (op_q == OP_ERASE);
  assign bus.ack0     = (state_q == RESP) && !grant_q;
  assign bus.ack1     = (state_q == RESP) && grant_q;
  assign bus.err      = (state_q == RESP) && err_q;
  assign bus.rdata    = rdata_q;
  assign bus.grant    = grant_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed bench for flash_arbiter with a scoreboard of
// expected acks and a small behavioural flash_driver responder.
// Define FLASH_ARB_TIMEOUT_EN to also exercise the busy-phase watchdog.
module tb_flash_arbiter;
  import flash_arb_pkg::*;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int SW     = 4;

  typedef struct {
    logic              port;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] drv_addr;
  logic [DATA_W-1:0] drv_wdata;
  logic [DATA_W-1:0] drv_rdata;
  logic              drv_en_read, drv_en_write, drv_en_erase;
  logic              drv_busy = 1'b0;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] hold_rdata;

  // driver model controls, written only by the main stimulus block
  bit model_nobusy = 0;
  bit model_stuck  = 0;
  int model_hold   = 1;
  int busy_cnt     = 0;

  // monitor counters, written only by the monitor
  int n_rd = 0, n_wr = 0, n_er = 0, n_ack = 0, n_viol = 0;

  flash_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  flash_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .START_WAIT (SW)
`ifdef FLASH_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (24'd16)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .drv_addr     (drv_addr),
    .drv_wdata    (drv_wdata),
    .drv_rdata    (drv_rdata),
    .drv_en_read  (drv_en_read),
    .drv_en_write (drv_en_write),
    .drv_en_erase (drv_en_erase),
    .drv_busy     (drv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural driver: busy rises the cycle after a strobe and holds model_hold cycles
  always @(posedge clk) begin
    if ((drv_en_read || drv_en_write || drv_en_erase) && !model_nobusy) begin
      drv_busy <= 1'b1;
      busy_cnt <= model_hold;
    end else if (drv_busy && !model_stuck) begin
      if (busy_cnt <= 1) drv_busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  // Count strobes and acks of each completed cycle
  always @(posedge clk) begin
    if (drv_en_read)  n_rd++;
    if (drv_en_write) n_wr++;
    if (drv_en_erase) n_er++;
    if (int'(drv_en_read) + int'(drv_en_write) + int'(drv_en_erase) > 1) n_viol++;
    if (bus.ack0 || bus.ack1) n_ack++;
  end

  // Hard stop if the directed sequence ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=stalled expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic port, input logic err, input logic is_read);
    exp_t e;
    if (is_read && !err) hold_rdata = drv_rdata;
    e.port  = port;
    e.err   = err;
    e.rdata = hold_rdata;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic port, input logic [1:0] op,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                               input logic exp_err);
    if (port) begin
      bus.op1 = op; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end else begin
      bus.op0 = op; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end
    pushExp(port, exp_err, op == OP_READ);
  endtask

  task automatic waitAck(input string tag, input int bound, output int n);
    bit seen;
    exp_t e;
    seen = 0;
    n = 0;
    while (!seen && n < bound) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.ack0 || bus.ack1) seen = 1;
    end
    checkOutput({tag, "_ack_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({tag, "_ack_port"}, {30'd0, bus.ack1, bus.ack0}, e.port ? 32'd2 : 32'd1);
        checkOutput({tag, "_err"}, 32'(bus.err), 32'(e.err));
        checkOutput({tag, "_rdata"}, 32'(bus.rdata), 32'(e.rdata));
        checkOutput({tag, "_grant"}, 32'(bus.grant), 32'(e.port));
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    hold_rdata = '0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ack0"}, 32'(bus.ack0), 32'd0);
    checkOutput({tag, "_ack1"}, 32'(bus.ack1), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    checkOutput({tag, "_grant"}, 32'(bus.grant), 32'd0);
    checkOutput({tag, "_drv_addr"}, 32'(drv_addr), 32'd0);
    checkOutput({tag, "_drv_wdata"}, 32'(drv_wdata), 32'd0);
    checkOutput({tag, "_strobes"}, {29'd0, drv_en_read, drv_en_write, drv_en_erase}, 32'd0);
  endtask

  initial begin
    int n;
    int snap_wr, snap_rd, snap_er, snap_ack;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] w0, w1;

    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = OP_READ; bus.op1 = OP_READ;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    drv_rdata = '0;
    hold_rdata = '0;
    #1;
    checkResetValues("reset_async");
    doReset();
    @(negedge clk);
    checkResetValues("reset_idle");

    // port 0 read, busy held 3 cycles, ack expected at cycle 6
    $display("[TB] port 0 read latency");
    model_hold = 3;
    drv_rdata = 16'hBEEF;
    applyStimulus(1'b0, OP_READ, 23'h000010, 16'h0000, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("rd_strobe", {29'd0, drv_en_read, drv_en_write, drv_en_erase}, 32'd4);
    checkOutput("rd_grant", 32'(bus.grant), 32'd0);
    checkOutput("rd_addr", 32'(drv_addr), 32'h10);
    @(posedge clk); @(negedge clk);
    checkOutput("rd_strobe_width", 32'(drv_en_read), 32'd0);
    waitAck("rd", 30, n);
    checkOutput("rd_latency", 32'(n + 2), 32'd6);
    bus.req0 = 1'b0;
    @(negedge clk);
    checkOutput("rd_ack_width", 32'(bus.ack0), 32'd0);
    checkOutput("rd_rdata_held", 32'(bus.rdata), 32'hBEEF);

    // both ports write from reset; held requests must alternate 0,1,0,1
    $display("[TB] round-robin writes");
    doReset();
    model_hold = 2;
    snap_wr = n_wr;
    a0 = 23'h012345; a1 = 23'h7F0001;
    w0 = 16'hA5A5;   w1 = 16'h5A5A;
    applyStimulus(1'b0, OP_WRITE, a0, w0, 1'b0);
    applyStimulus(1'b1, OP_WRITE, a1, w1, 1'b0);
    pushExp(1'b0, 1'b0, 1'b0);
    pushExp(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      waitAck($sformatf("rr%0d", k), 40, n);
      checkOutput($sformatf("rr%0d_drv_addr", k), 32'(drv_addr), (k % 2 == 1) ? 32'(a1) : 32'(a0));
      checkOutput($sformatf("rr%0d_drv_wdata", k), 32'(drv_wdata), (k % 2 == 1) ? 32'(w1) : 32'(w0));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rr_write_strobes", 32'(n_wr - snap_wr), 32'd4);

    // reserved op on port 1: immediate error ack, no strobe, driver address kept
    $display("[TB] reserved op");
    snap_wr = n_wr; snap_rd = n_rd; snap_er = n_er;
    applyStimulus(1'b1, OP_RSVD, 23'h00ABCD, 16'h1111, 1'b1);
    waitAck("rsvd", 10, n);
    checkOutput("rsvd_latency", 32'(n), 32'd1);
    checkOutput("rsvd_drv_addr", 32'(drv_addr), 32'(a1));
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rsvd_no_strobe", 32'((n_wr - snap_wr) + (n_rd - snap_rd) + (n_er - snap_er)), 32'd0);

    // erase whose driver never raises busy: completes after the start window
    $display("[TB] erase without busy");
    model_nobusy = 1;
    snap_er = n_er;
    applyStimulus(1'b0, OP_ERASE, 23'h004000, 16'h0000, 1'b0);
    waitAck("erase", 30, n);
    checkOutput("erase_latency", 32'(n), 32'(2 + SW));
    checkOutput("erase_drv_addr", 32'(drv_addr), 32'h004000);
    bus.req0 = 1'b0;
    @(negedge clk);
    checkOutput("erase_strobes", 32'(n_er - snap_er), 32'd1);
    model_nobusy = 0;

`ifdef FLASH_ARB_TIMEOUT_EN
    // busy stuck high: watchdog error ack, then no new strobe until busy falls
    $display("[TB] busy watchdog");
    model_hold = 1;
    model_stuck = 1;
    drv_rdata = 16'hDEAD;
    applyStimulus(1'b1, OP_READ, 23'h000777, 16'h0000, 1'b1);
    waitAck("tmo", 60, n);
    checkOutput("tmo_latency", 32'(n), 32'd19);
    bus.req1 = 1'b0;
    snap_wr = n_wr; snap_ack = n_ack;
    applyStimulus(1'b0, OP_WRITE, 23'h000888, 16'h4242, 1'b0);
    repeat (8) @(negedge clk);
    checkOutput("tmo_hold_strobe", 32'(n_wr - snap_wr), 32'd0);
    checkOutput("tmo_hold_ack", 32'(n_ack - snap_ack), 32'd0);
    model_stuck = 0;
    waitAck("tmo_next", 20, n);
    bus.req0 = 1'b0;
    @(negedge clk);
    checkOutput("tmo_next_strobe", 32'(n_wr - snap_wr), 32'd1);
`endif

    // reset during WAIT_DONE with busy high, then pending request waits for busy
    $display("[TB] reset mid-operation");
    model_hold = 1;
    model_stuck = 1;
    drv_rdata = 16'h1234;
    applyStimulus(1'b0, OP_READ, 23'h000055, 16'h0000, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    hold_rdata = '0;
    pushExp(1'b0, 1'b0, 1'b1);
    snap_rd = n_rd; snap_ack = n_ack;
    repeat (6) @(negedge clk);
    checkOutput("midrst_no_strobe", 32'(n_rd - snap_rd), 32'd0);
    checkOutput("midrst_no_ack", 32'(n_ack - snap_ack), 32'd0);
    model_stuck = 0;
    waitAck("midrst_resume", 20, n);
    bus.req0 = 1'b0;
    @(negedge clk);
    checkOutput("midrst_strobe", 32'(n_rd - snap_rd), 32'd1);

    checkOutput("strobe_onehot", 32'(n_viol), 32'd0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
